bram_banked_buffer: RTL and testbench
=====================================

# bram_banked_buffer

Parametrised simple-dual-port block-RAM buffer: the next generation of the team's convolution scratch memory. It adds byte-enable writes, a registered and configurable read pipeline with a valid strobe, selectable read/write collision behaviour, and a hardware clear engine. The clear engine zeroes the array after reset or on command, writing all banks in parallel. It sits between the AXI/DMA loader, which writes, and the convolution datapath, which reads.

## Interface
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; multiple of 8.
- NUM_BANKS, 4, power of two ≥1, ≤ depth; word address a lives in bank a % NUM_BANKS, row a / NUM_BANKS.
- READ_LATENCY, 1, 1 or 2 cycles from read request to o_valid.
- COLLISION_MODE, 0, 0 = read-first (old data), 1 = write-first (new data, byte-merged).
- CLEAR_ON_RESET, 1, 1 = clear sequence starts automatically when reset deasserts.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  pulse: start clear sequence.
- o_busy  out  1  clear sequence in progress; write and read requests ignored.
- i_we  in  1  write request.
- i_wbe  in  DATA_WIDTH/8  byte enables; bit k covers i_data[8k+7:8k].
- i_write_addr  in  ADDR_WIDTH  write address.
- i_data  in  DATA_WIDTH  write data.
- i_re  in  1  read request.
- i_read_addr  in  ADDR_WIDTH  read address.
- o_data  out  DATA_WIDTH  read data; 0 whenever o_valid = 0.
- o_valid  out  1  o_data carries the result of a read request.

## Operation
- Reset (i_rst_n = 0): o_valid = 0, o_data = 0, read pipeline flushed, clear counter = 0. Array contents are not touched by reset. State = CLEAR with o_busy = 1 if CLEAR_ON_RESET, else IDLE with o_busy = 0.
- FSM states:
  - IDLE: serves reads and writes.
  - CLEAR: row counter r = 0 … DEPTH/NUM_BANKS−1; each cycle writes 0 to row r of every bank.
- Transitions:
  - IDLE→CLEAR when i_clear = 1.
  - CLEAR→IDLE after row DEPTH/NUM_BANKS−1 is written.
  - i_clear in CLEAR is ignored; no restart.
- Write: in IDLE with i_we = 1, bytes with i_wbe[k] = 1 are updated at i_write_addr. i_wbe = 0 is a no-op.
- Read: in IDLE with i_re = 1, the word at i_read_addr is returned with o_valid = 1 exactly READ_LATENCY cycles later. Back-to-back reads give one result per cycle.
- Collision (i_we and i_re in the same cycle, same address):
  - Mode 0 returns the pre-write word.
  - Mode 1 returns the pre-write word with enabled bytes replaced by i_data.
  - The array is updated in both modes.
- Simultaneous i_clear with i_we/i_re in IDLE: clear wins; that write and that read are dropped, with no o_valid.
- Reads issued before CLEAR entry still complete and deliver pre-clear data.
- Reset asserted mid-clear: counter returns to 0. With CLEAR_ON_RESET = 1 the clear restarts from row 0 on deassertion.

## Timing
- Clear: o_busy rises in the cycle after i_clear is sampled, stays high exactly DEPTH/NUM_BANKS cycles, then falls. The first request accepted is in the first cycle with o_busy = 0.
- After reset deassertion with CLEAR_ON_RESET = 1, o_busy is already high and lasts DEPTH/NUM_BANKS cycles.
- Write data is visible to a read request issued the next cycle; same-cycle visibility follows COLLISION_MODE.
- READ_LATENCY = 2 adds an output register after the BRAM data register, for timing closure at 300 MHz on the Ultra96-V2.
- o_data is zeroed by gating it with o_valid; there is no combinational path from i_read_addr to o_data.

## Structure
- Package bram_pkg holds:
  - the collision mode enum (COLL_READ_FIRST, COLL_WRITE_FIRST);
  - the clear FSM state typedef (ST_IDLE, ST_CLEAR);
  - the localparam helper for row width: ADDR_WIDTH − $clog2(NUM_BANKS).
- Sub-module bram_bank: one simple-dual-port byte-enabled bank with a registered read and RAM_STYLE "BLOCK", instantiated NUM_BANKS times.
- The top level holds the bank select/decode, the read-bank select pipeline, the collision bypass register, the clear FSM/counter and the valid pipeline.

## Test plan
- Reset with CLEAR_ON_RESET = 1, ADDR_WIDTH = 6, NUM_BANKS = 4 -> o_busy high for exactly 16 cycles, then read address 0x2A -> o_data = 0, o_valid = 1 after READ_LATENCY.
- Write 0xDEADBEEF to address 5 (i_wbe = 4'hF), then write 0x000000AA with i_wbe = 4'b0001, then read 5 -> 0xDEADBEAA.
- Same-cycle write 0x11111111 / read, address 9, old value 0x22222222 -> mode 0 returns 0x22222222, mode 1 returns 0x11111111; a subsequent read returns 0x11111111 in both modes.
- Read addresses 0–7 back-to-back with READ_LATENCY = 2 -> eight consecutive o_valid cycles starting 2 cycles after the first request, data in order, o_data = 0 before and after.
- i_clear together with i_we (address 3, 0x55) -> write dropped, o_busy high DEPTH/NUM_BANKS cycles, read 3 -> 0. A second i_clear mid-sequence does not extend o_busy.
- Assert i_rst_n low at row 7 of a clear, deassert -> clear restarts at row 0, with the full DEPTH/NUM_BANKS busy cycles.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared types and sizing helper for the banked block-RAM buffer
package bram_pkg;
  typedef enum logic {COLL_READ_FIRST, COLL_WRITE_FIRST} coll_mode_t;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  function automatic int row_width(input int addr_width, input int num_banks);
    return addr_width - $clog2(num_banks);
  endfunction
endpackage

// File: rtl/bram_bank.sv
// bram_bank: one simple-dual-port byte-enabled block RAM bank with a registered read
module bram_bank #(
  parameter int ROW_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ROW_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ROW_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);
  (* ram_style = "block" *) logic [DATA_W-1:0] mem [2**ROW_W];
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_W/8; k++)
      if (we && wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/bram_banked_buffer.sv
// bram_banked_buffer: banked byte-enable BRAM buffer with clear engine and valid-strobed read pipeline
module bram_banked_buffer
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BANKS      = 4,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  output logic                    o_busy,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_read_addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid
);
  localparam int ROW_W = row_width(ADDR_WIDTH, NUM_BANKS);
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;
  localparam coll_mode_t COLL = coll_mode_t'(COLLISION_MODE);
  state_t state;
  logic [ROW_W-1:0] clr_row, wrow, rrow;
  logic [BANK_W-1:0] wbank, rbank, rbank_q;
  logic wr_ok, rd_ok, v1, coll_q;
  logic [NB-1:0] wbe_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_word;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  assign o_busy = state == ST_CLEAR;
  assign wr_ok = !o_busy && !i_clear && i_we;
  assign rd_ok = !o_busy && !i_clear && i_re;
  assign wbank = BANK_W'(i_write_addr % NUM_BANKS);
  assign rbank = BANK_W'(i_read_addr % NUM_BANKS);
  assign wrow = ROW_W'(i_write_addr / NUM_BANKS);
  assign rrow = ROW_W'(i_read_addr / NUM_BANKS);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_IDLE;
      clr_row <= '0;
    end else if (state == ST_IDLE) begin
      if (i_clear) state <= ST_CLEAR;
      clr_row <= '0;
    end else begin
      clr_row <= clr_row + 1'b1;
      if (clr_row == LAST_ROW) state <= ST_IDLE;
    end
  end
  // while clearing, every bank is written with zero at the same row
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bram_bank #(.ROW_W(ROW_W), .DATA_W(DATA_WIDTH)) u_bank (
      .clk  (i_clk),
      .we   (o_busy || (wr_ok && wbank == BANK_W'(b))),
      .wbe  (o_busy ? {NB{1'b1}} : i_wbe),
      .waddr(o_busy ? clr_row : wrow),
      .wdata(o_busy ? {DATA_WIDTH{1'b0}} : i_data),
      .re   (rd_ok && rbank == BANK_W'(b)),
      .raddr(rrow),
      .rdata(bank_rdata[b])
    );
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0;
      rbank_q <= '0;
      coll_q <= 1'b0;
      wbe_q <= '0;
      wdata_q <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) begin
        rbank_q <= rbank;
        coll_q <= COLL == COLL_WRITE_FIRST && wr_ok && i_write_addr == i_read_addr;
        wbe_q <= i_wbe;
        wdata_q <= i_data;
      end
    end
  end
  // banks are read-first; write-first merges the captured write bytes afterwards
  always_comb begin
    rd_word = bank_rdata[rbank_q];
    for (int k = 0; k < NB; k++)
      if (coll_q && wbe_q[k]) rd_word[8*k +: 8] = wdata_q[8*k +: 8];
  end
  if (READ_LATENCY == 2) begin : g_lat2
    logic v2;
    logic [DATA_WIDTH-1:0] d2;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        d2 <= v1 ? rd_word : '0;
      end
    end
    assign o_valid = v2;
    assign o_data = d2;
  end else begin : g_lat1
    assign o_valid = v1;
    assign o_data = v1 ? rd_word : '0;
  end
endmodule

// File: tb/tb_bram_banked_buffer.sv
// tb_bram_banked_buffer: directed checks on read-first/lat1, write-first/lat2 and no-auto-clear instances
module tb_bram_banked_buffer;
  logic clk = 0, rst_n = 0, clear = 0, we = 0, re = 0;
  logic [3:0] wbe = 0;
  logic [5:0] waddr = 0, raddr = 0;
  logic [31:0] wdata = 0;
  logic busy0, valid0, busy1, valid1, busy2, valid2;
  logic [31:0] data0, data1, data2;
  int n_tests = 0, n_fail = 0, n;
  logic [31:0] d [8];
  always #5 clk = ~clk;
  bram_banked_buffer #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_BANKS(4), .READ_LATENCY(1),
    .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy0), .i_we(we), .i_wbe(wbe),
    .i_write_addr(waddr), .i_data(wdata), .i_re(re), .i_read_addr(raddr), .o_data(data0), .o_valid(valid0));
  bram_banked_buffer #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_BANKS(4), .READ_LATENCY(2),
    .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy1), .i_we(we), .i_wbe(wbe),
    .i_write_addr(waddr), .i_data(wdata), .i_re(re), .i_read_addr(raddr), .o_data(data1), .o_valid(valid1));
  bram_banked_buffer #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_BANKS(4), .READ_LATENCY(1),
    .COLLISION_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy2), .i_we(we), .i_wbe(wbe),
    .i_write_addr(waddr), .i_data(wdata), .i_re(re), .i_read_addr(raddr), .o_data(data2), .o_valid(valid2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic write_word(input logic [5:0] a, input logic [31:0] dat, input logic [3:0] be);
    we = 1; waddr = a; wdata = dat; wbe = be;
    tick;
    we = 0; wbe = 0;
  endtask
  task automatic read_word(input string tag, input logic [5:0] a, input logic [31:0] e0, input logic [31:0] e1);
    re = 1; raddr = a;
    tick;
    re = 0; we = 0; wbe = 0;
    check($sformatf("%s_v0", tag), valid0, 1);
    check($sformatf("%s_d0", tag), data0, e0);
    check($sformatf("%s_v1_early", tag), valid1, 0);
    tick;
    check($sformatf("%s_v1", tag), valid1, 1);
    check($sformatf("%s_d1", tag), data1, e1);
    check($sformatf("%s_v0_after", tag), valid0, 0);
    check($sformatf("%s_d0_after", tag), data0, 0);
  endtask
  task automatic count_busy(output int cnt, input int pulse_at);
    cnt = 0;
    while (busy0 && cnt < 100) begin
      clear = (cnt == pulse_at);
      cnt++;
      tick;
    end
    clear = 0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) d[i] = 32'h1000_0000 + i * 32'h0101_0101;
    tick; tick;
    check("rst_busy0", busy0, 1);
    check("rst_busy2", busy2, 0);
    check("rst_valid0", valid0, 0);
    check("rst_data0", data0, 0);
    check("rst_valid1", valid1, 0);
    rst_n = 1;
    count_busy(n, -1);
    check("reset_clear_cycles", n, 16);
    check("busy1_done", busy1, 0);
    read_word("rd_2a_zero", 6'h2A, 0, 0);
    write_word(5, 32'hDEAD_BEEF, 4'hF);
    write_word(5, 32'h0000_00AA, 4'b0001);
    read_word("byte_en", 5, 32'hDEAD_BEAA, 32'hDEAD_BEAA);
    write_word(9, 32'h2222_2222, 4'hF);
    we = 1; waddr = 9; wdata = 32'h1111_1111; wbe = 4'hF;
    read_word("coll_full", 9, 32'h2222_2222, 32'h1111_1111);
    read_word("after_coll", 9, 32'h1111_1111, 32'h1111_1111);
    we = 1; waddr = 9; wdata = 32'h0000_3300; wbe = 4'b0010;
    read_word("coll_byte", 9, 32'h1111_1111, 32'h1111_3311);
    read_word("after_coll_byte", 9, 32'h1111_3311, 32'h1111_3311);
    for (int i = 0; i < 8; i++) write_word(6'(i), d[i], 4'hF);
    for (int k = 0; k < 10; k++) begin
      re = k < 8; raddr = 6'(k);
      tick;
      if (k == 0 || k == 9) begin
        check($sformatf("b2b_v1_idle%0d", k), valid1, 0);
        check($sformatf("b2b_d1_idle%0d", k), data1, 0);
      end else begin
        check($sformatf("b2b_v1_%0d", k), valid1, 1);
        check($sformatf("b2b_d1_%0d", k), data1, d[k-1]);
      end
    end
    re = 1; raddr = 4;
    tick;
    check("pre_clear_v0", valid0, 1);
    check("pre_clear_d0", data0, d[4]);
    clear = 1; we = 1; waddr = 3; wdata = 32'h55; wbe = 4'hF; re = 1; raddr = 3;
    tick;
    clear = 0; we = 0; wbe = 0; re = 0;
    check("clr_busy_rise", busy0, 1);
    check("clr_drop_v0", valid0, 0);
    check("pre_clear_v1", valid1, 1);
    check("pre_clear_d1", data1, d[4]);
    tick;
    check("clr_drop_v1", valid1, 0);
    count_busy(n, 4);
    check("clear_cycles", 1 + n, 16);
    read_word("cleared_3", 3, 0, 0);
    read_word("cleared_5", 5, 0, 0);
    write_word(2, 32'hCAFE_F00D, 4'hF);
    clear = 1;
    tick;
    clear = 0;
    for (int i = 0; i < 7; i++) tick;
    check("mid_busy", busy0, 1);
    rst_n = 0;
    #1;
    check("mid_rst_busy0", busy0, 1);
    check("mid_rst_busy2", busy2, 0);
    tick; tick;
    rst_n = 1;
    count_busy(n, -1);
    check("restart_clear_cycles", n, 16);
    read_word("after_restart", 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
